seq_magnitude_comparator: RTL
=============================

Name: seq_magnitude_comparator

Overview:
- Parametrised, multi-cycle magnitude comparator for WIDTH-bit operands, signed or unsigned.
- Examines CHUNK bits per clock, MSB chunk first, and stops at the first differing chunk.
- Produces registered greater/equal/less flags with a start/busy/done handshake.
- Serves as the area-lean wide comparator in the comparator library, next to the combinational 2-bit cell.

Parameters:
- WIDTH, 16: operand width in bits; must be a multiple of CHUNK and at least 2.
- CHUNK, 2: bits compared per cycle, in the range 1..WIDTH.
- NCH, WIDTH/CHUNK: derived localparam, number of chunks; not overridable.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  request; sampled only when the FSM is in IDLE or DONE.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned compare.
- a  input  WIDTH  operand A; captured on an accepted start.
- b  input  WIDTH  operand B; captured on an accepted start.
- busy  output  1  high while in COMPARE.
- done  output  1  one-cycle pulse when the result becomes valid.
- greater  output  1  A > B; held until the next accepted start.
- equal  output  1  A == B; held until the next accepted start.
- less  output  1  A < B; held until the next accepted start.
- cycles  output  $clog2(NCH+1)  number of COMPARE cycles used by the last operation (1..NCH).

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: state=IDLE; busy, done, greater, equal, less = 0; cycles = 0; operand registers = 0.
- FSM states: IDLE, COMPARE, DONE.
- IDLE:
  - start=1 captures a, b and signed_mode, sets chunk index idx=0, and moves to COMPARE.
  - The result flags are cleared on that edge.
- Signed handling: at capture, if signed_mode=1, invert the MSB of both captured operands (offset-binary conversion). The unsigned chunk compare is then correct for two's complement.
- COMPARE, one chunk per cycle:
  - Chunk idx covers bits [WIDTH-1-idx*CHUNK -: CHUNK].
  - Chunk A > chunk B: set greater, cycles=idx+1, go to DONE.
  - Chunk A < chunk B: set less, cycles=idx+1, go to DONE.
  - Chunks equal and idx==NCH-1: set equal, cycles=NCH, go to DONE.
  - Chunks equal otherwise: idx=idx+1, stay in COMPARE.
- Result flags: exactly one of greater/equal/less is high from the first DONE cycle until the next accepted start.
- busy: high in every COMPARE cycle; low in IDLE and DONE.
- done: high for exactly the one cycle spent in DONE.
- Latency: if the first differing chunk is k (1-based), done is high in cycle k+1 after the start edge. Minimum 2 cycles, maximum NCH+1 cycles (equal operands).
- DONE exit and back-to-back:
  - Next state is IDLE, unless start=1, in which case the new operands are captured and the FSM goes straight to COMPARE.
  - A back-to-back start clears the flags on the following edge, so done and valid flags still overlap for one cycle.
- start while busy: ignored. Operands are not recaptured and the result is unaffected.
- Input stability: a, b and signed_mode may change freely after capture.
- Reset mid-operation: immediate return to IDLE with all outputs 0; the partial result is discarded.
- CHUNK==WIDTH: the compare always completes in one COMPARE cycle (cycles=1).
- Counter width: no wrap is possible, because idx never exceeds NCH-1.

Decomposition:
- Package cmp_pkg:
  - FSM state encoding constants (IDLE=2'd0, COMPARE=2'd1, DONE=2'd2).
  - Result-code constants (GT, EQ, LT).
  - Helper function computing NCH and the cycles width.
- Sub-module cmp_chunk: combinational, parameter CHUNK, inputs ca/cb [CHUNK-1:0], outputs gt/eq/lt (exactly one high). Built as a ripple MSB-first structure and instantiated once, on the muxed current chunk.

Test Plan (WIDTH=16, CHUNK=2):
- Reset: hold rst_n=0, then release with start=0 -> all outputs 0, busy=0, for 5 cycles; the result is never written.
- Unsigned MSB decision: start, signed_mode=0, a=16'h8000, b=16'h7FFF -> greater=1, cycles=1, done high exactly 2 cycles after the start edge.
- Signed MSB decision: same operands with signed_mode=1 -> less=1, cycles=1.
- Equal and LSB-decided operands:
  - a=b=16'h1234 -> equal=1, cycles=8, done at cycle 9, busy high for cycles 1..8.
  - a=16'h0001, b=16'h0002 unsigned -> less=1, cycles=8.
- Protocol:
  - Pulse start with a=0, b=1 while busy -> ignored; the original result stands.
  - Assert start in the DONE cycle with a=5, b=3 -> captured back-to-back; greater=1 follows with no IDLE cycle in between.
- Reset mid-compare: drop rst_n in COMPARE cycle 4 of an equal-operand run -> busy, done and flags go to 0 asynchronously; the next start completes normally.

Source files
------------

// File: rtl/cmp_pkg.sv
// ----------------------------------------------------------------------------
// cmp_pkg
// Shared definitions for the sequential magnitude comparator:
//   - cmpState_e  : FSM state encoding (IDLE, COMPARE, DONE)
//   - cmpResult_e : per-chunk / final result code (GT, EQ, LT)
//   - calcNch / calcCyclesW / calcIdxW : derived-size helpers
// ----------------------------------------------------------------------------
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } cmpState_e;

    typedef enum logic [1:0] {
        GT = 2'd0,
        EQ = 2'd1,
        LT = 2'd2
    } cmpResult_e;

    // Number of chunks an operand splits into
    function automatic int calcNch(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Width needed to hold a cycle count of 0..nch
    function automatic int calcCyclesW(input int nch);
        return $clog2(nch + 1);
    endfunction

    // Width of the chunk index 0..nch-1, never narrower than one bit
    function automatic int calcIdxW(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/cmp_chunk.sv
// ----------------------------------------------------------------------------
// cmp_chunk
// Combinational unsigned compare of one CHUNK-bit slice.
// Ports:
//   ca, cb : chunk of operand A / operand B
//   gt     : ca > cb
//   eq     : ca == cb
//   lt     : ca < cb
// Exactly one of gt/eq/lt is high.
// ----------------------------------------------------------------------------
module cmp_chunk #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] ca,
    input  logic [CHUNK-1:0] cb,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    // Ripple from the MSB down: the first differing bit decides, and once a
    // decision is made the lower bits can no longer change it.
    always_comb begin
        gt = 1'b0;
        lt = 1'b0;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (!gt && !lt && (ca[i] != cb[i])) begin
                gt = ca[i];
                lt = cb[i];
            end
        end
        eq = ~(gt | lt);
    end

endmodule

// File: rtl/seq_magnitude_comparator.sv
// ----------------------------------------------------------------------------
// seq_magnitude_comparator
// Multi-cycle WIDTH-bit magnitude comparator, signed or unsigned. Compares
// CHUNK bits per clock starting at the MSB chunk and stops at the first
// differing chunk.
// Ports:
//   clk, rst_n     : clock (rising edge), async active-low reset
//   start          : request, accepted in IDLE or DONE
//   signed_mode    : 1 = two's-complement compare, 0 = unsigned
//   a, b           : operands, captured on an accepted start
//   busy           : high while comparing
//   done           : one-cycle pulse when the result becomes valid
//   greater/equal/less : result flags, held until the next accepted start
//   cycles         : compare cycles used by the last operation
// ----------------------------------------------------------------------------
module seq_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int CHUNK = 2,
    localparam int NCH   = calcNch(WIDTH, CHUNK),
    localparam int CYCW  = calcCyclesW(NCH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             greater,
    output logic             equal,
    output logic             less,
    output logic [CYCW-1:0]  cycles
);

    localparam int             IDXW     = calcIdxW(NCH);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

    cmpState_e         state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              greater_q, greater_d;
    logic              equal_q, equal_d;
    logic              less_q, less_d;
    logic [CYCW-1:0]   cycles_q, cycles_d;

    logic [CHUNK-1:0]  aChunks [NCH];
    logic [CHUNK-1:0]  bChunks [NCH];
    logic [CHUNK-1:0]  curA, curB;
    logic              chunkGt, chunkEq, chunkLt;
    cmpResult_e        chunkRes;
    logic              acceptStart;

    // Slice the captured operands into chunks, index 0 being the MSB chunk
    for (genvar g = 0; g < NCH; g++) begin : g_chunks
        assign aChunks[g] = a_q[WIDTH-1-g*CHUNK -: CHUNK];
        assign bChunks[g] = b_q[WIDTH-1-g*CHUNK -: CHUNK];
    end

    assign curA = aChunks[idx_q];
    assign curB = bChunks[idx_q];

    cmp_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .ca (curA),
        .cb (curB),
        .gt (chunkGt),
        .eq (chunkEq),
        .lt (chunkLt)
    );

    assign chunkRes    = chunkGt ? GT : (chunkEq ? EQ : LT);
    assign acceptStart = start && ((state_q == IDLE) || (state_q == DONE));

    // State and datapath registers; reset discards any partial result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            idx_q     <= '0;
            greater_q <= 1'b0;
            equal_q   <= 1'b0;
            less_q    <= 1'b0;
            cycles_q  <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            idx_q     <= idx_d;
            greater_q <= greater_d;
            equal_q   <= equal_d;
            less_q    <= less_d;
            cycles_q  <= cycles_d;
        end
    end

    // Next-state logic. Signed operands get their MSB flipped at capture
    // (offset binary), so the chunk compare can stay purely unsigned.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        idx_d     = idx_q;
        greater_d = greater_q;
        equal_d   = equal_q;
        less_d    = less_q;
        cycles_d  = cycles_q;

        if (acceptStart) begin
            a_d       = {a[WIDTH-1] ^ signed_mode, a[WIDTH-2:0]};
            b_d       = {b[WIDTH-1] ^ signed_mode, b[WIDTH-2:0]};
            idx_d     = '0;
            greater_d = 1'b0;
            equal_d   = 1'b0;
            less_d    = 1'b0;
            state_d   = COMPARE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                COMPARE: begin
                    if (chunkRes == GT) begin
                        greater_d = 1'b1;
                        cycles_d  = CYCW'(idx_q) + CYCW'(1);
                        state_d   = DONE;
                    end else if (chunkRes == LT) begin
                        less_d   = 1'b1;
                        cycles_d = CYCW'(idx_q) + CYCW'(1);
                        state_d  = DONE;
                    end else if (idx_q == LAST_IDX) begin
                        equal_d  = 1'b1;
                        cycles_d = CYCW'(NCH);
                        state_d  = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign busy    = (state_q == COMPARE);
    assign done    = (state_q == DONE);
    assign greater = greater_q;
    assign equal   = equal_q;
    assign less    = less_q;
    assign cycles  = cycles_q;

endmodule
